nios_keys_pio_in: RTL

//  Avalon-MM slave input PIO. It is the read-side counterpart of the LED output PIO.

---
 rtl/nios_keys_pio_in.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nios_keys_pio_in.sv
// Input PIO: synchronises, debounces and edge-captures push-buttons/switches for the Nios II.
// Latency: in_port to debounced is 2 + DEBOUNCE_CYCLES clk; readdata 1 clk after the read strobe; irq 1 clk after capture.
// Backpressure: none; the slave always accepts reads and writes with no wait states.
//
// Ports:
//   clk, reset_n            clock and async active-low reset
//   address[1:0]            0 data, 1 reserved (reads 0), 2 irqmask, 3 edgecapture (write-1-to-clear)
//   chipselect, read_n,     Avalon-MM slave strobes (read/write strobes active low)
//   write_n, writedata[31:0]
//   in_port[WIDTH-1:0]      raw asynchronous inputs
//   readdata[31:0]          registered read data, upper bits zero
//   irq                     registered level interrupt: any unmasked captured edge
module nios_keys_pio_in #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_bits;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry register content.
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Two-flop synchroniser; reset to the idle level so nothing moves out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= INIT_VALUE;
            sync      <= INIT_VALUE;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign debounced = sync;
        end else begin : g_debounce
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
                logic [CW-1:0] cnt;
                // The counter only runs while sync disagrees with the debounced level, and the
                // debounced bit takes the new level on the DEBOUNCE_CYCLES-th consecutive
                // disagreeing cycle. Clearing on update keeps it from ever wrapping.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt          <= '0;
                        debounced[i] <= INIT_VALUE[i];
                    end else if (sync[i] == debounced[i]) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt          <= '0;
                        debounced[i] <= sync[i];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Delayed copy resets to the idle level, so no edge is seen coming out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= INIT_VALUE;
        else          prev <= debounced;
    end

    assign rise = debounced & ~prev;
    assign fall = ~debounced & prev;

    always_comb begin
        event_bits = rise | fall;
        if (EDGE_TYPE == 0)      event_bits = rise;
        else if (EDGE_TYPE == 1) event_bits = fall;
    end

    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as its clear wins, so no event is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irqmask     <= '0;
            irq         <= 1'b0;
        end else begin
            edgecapture <= (edgecapture & ~clear_bits) | event_bits;
            if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
            irq <= |(edgecapture & irqmask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = debounced;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    // readdata holds its previous value between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   readdata <= '0;
        else if (rd_en) readdata <= rd_mux;
    end

endmodule
